// File: rtl/jtcop_obj_linebuf_if.sv
// Write port between the object draw engine (master) and the object line buffer (slave).
// Handshake: a request is accepted on every clk edge where buf_we && buf_ok are both high;
// the master holds buf_addr/buf_data stable while buf_we is high and buf_ok is low.
interface jtcop_obj_linebuf_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic          buf_ok;

    modport master (output buf_we, buf_addr, buf_data, input buf_ok);
    modport slave  (input buf_we, buf_addr, buf_data, output buf_ok);
endinterface

// File: rtl/jtcop_obj_linebuf.sv
// Double-buffered object line buffer: one bank is filled by the draw engine while the other is scanned out
// and erased behind the beam. Define JTCOP_OBJ_PRIO_EN for first-write-wins read-modify-write writes.
module jtcop_obj_linebuf #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   HS,
    input  logic                   LHBL,
    input  logic [AW-1:0]          hdump,
    jtcop_obj_linebuf_if.slave     bus,
    output logic [DW-1:0]          pxl,
    output logic                   wr_bank,
    output logic [1:0]             wr_st
);
    localparam int DEPTH = 2 ** (AW + 1);

    typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_CHK, ST_WR} wr_state_t;

    logic [DW-1:0] mem [DEPTH];
    logic          hs_l;
    logic          hs_rise;
    logic          erase_pend;
    logic [AW-1:0] erase_addr;
    logic          erase_bank;
    logic          mem_we;
    logic [AW:0]   mem_wa;
    logic [DW-1:0] mem_wd;
    logic          buf_ok;
    logic          opaque;
    wr_state_t     state;

    assign hs_rise    = HS & ~hs_l;
    assign opaque     = bus.buf_data[3:0] != 4'd0;
    assign bus.buf_ok = buf_ok;
    assign wr_st      = state;

    // Scan-out side; the erase bank is latched so a swap between read and erase cannot misdirect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l       <= 1'b0;
            wr_bank    <= 1'b0;
            pxl        <= '0;
            erase_pend <= 1'b0;
            erase_addr <= '0;
            erase_bank <= 1'b0;
        end else begin
            hs_l       <= HS;
            erase_pend <= 1'b0;
            if (hs_rise) wr_bank <= ~wr_bank;
            if (pxl_cen) begin
                if (LHBL) begin
                    pxl        <= mem[{~wr_bank, hdump}];
                    erase_pend <= 1'b1;
                    erase_addr <= hdump;
                    erase_bank <= ~wr_bank;
                end else begin
                    pxl <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (erase_pend) mem[{erase_bank, erase_addr}] <= '0;
    end

`ifdef JTCOP_OBJ_PRIO_EN
    wr_state_t     st_nx;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_data;
    logic          l_bank;
    logic [DW-1:0] chk_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RST;
            l_addr <= '0;
            l_data <= '0;
            l_bank <= 1'b0;
        end else begin
            state <= st_nx;
            if (state == ST_IDLE && bus.buf_we && opaque) begin
                l_addr <= bus.buf_addr;
                l_data <= bus.buf_data;
                l_bank <= wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        chk_data <= mem[{l_bank, l_addr}];
    end

    // Opaque pixel only lands if the target still holds a transparent pixel.
    always_comb begin
        st_nx  = state;
        buf_ok = 1'b0;
        mem_we = 1'b0;
        mem_wa = {l_bank, l_addr};
        mem_wd = l_data;
        case (state)
            ST_RST:  st_nx = ST_IDLE;
            ST_IDLE: begin
                buf_ok = 1'b1;
                if (bus.buf_we && opaque) st_nx = ST_CHK;
            end
            ST_CHK:  st_nx = ST_WR;
            ST_WR: begin
                mem_we = chk_data[3:0] == 4'd0;
                st_nx  = ST_IDLE;
            end
            default: st_nx = ST_IDLE;
        endcase
    end
`else
    assign state  = ST_IDLE;
    assign buf_ok = 1'b1;
    assign mem_we = bus.buf_we & opaque & ~rst;
    assign mem_wa = {wr_bank, bus.buf_addr};
    assign mem_wd = bus.buf_data;
`endif
endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// Self-checking bench for jtcop_obj_linebuf: a two-bank line model predicts every scanned pixel.
module tb_jtcop_obj_linebuf;
    localparam int DW = 8;
    localparam int AW = 8;
`ifdef JTCOP_OBJ_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pxl_cen = 1'b0;
    logic          HS = 1'b0;
    logic          LHBL = 1'b1;
    logic [AW-1:0] hdump = '0;
    logic [DW-1:0] pxl;
    logic          wr_bank;
    logic [1:0]    wr_st;

    jtcop_obj_linebuf_if #(.DW(DW), .AW(AW)) bus ();

    jtcop_obj_linebuf #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .HS      (HS),
        .LHBL    (LHBL),
        .hdump   (hdump),
        .bus     (bus.slave),
        .pxl     (pxl),
        .wr_bank (wr_bank),
        .wr_st   (wr_st)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [2][256];
    logic          model_bank;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int b;
        b = int'(model_bank);
        if (d[3:0] != 4'd0) begin
            if (!PRIO || model[b][a][3:0] == 4'd0) model[b][a] = d;
        end
    endtask

    task automatic wait_ok(input int exp_stall);
        int n;
        n = 0;
        while (!bus.buf_ok && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ok_stall", n, exp_stall);
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        bus.buf_we   = 1'b1;
        bus.buf_addr = a;
        bus.buf_data = d;
        n = 0;
        while (!bus.buf_ok && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("wr_ok", bus.buf_ok, 1);
        model_write(a, d);
        @(negedge clk);
        bus.buf_we = 1'b0;
        wait_ok((PRIO && d[3:0] != 4'd0) ? 2 : 0);
    endtask

    task automatic hs_pulse();
        @(negedge clk);
        HS = 1'b1;
        @(negedge clk);
        HS = 1'b0;
        model_bank = ~model_bank;
        check("bank", wr_bank, model_bank);
        @(negedge clk);
    endtask

    task automatic hs_with_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        HS           = 1'b1;
        bus.buf_we   = 1'b1;
        bus.buf_addr = a;
        bus.buf_data = d;
        check("hs_wr_ok", bus.buf_ok, 1);
        model_write(a, d);
        @(negedge clk);
        HS         = 1'b0;
        bus.buf_we = 1'b0;
        model_bank = ~model_bank;
        check("hs_wr_bank", wr_bank, model_bank);
        wait_ok(PRIO ? 2 : 0);
        @(negedge clk);
    endtask

    task automatic scan(input int lo, input int hi, input logic lhbl, input bit chk);
        int            rb;
        logic [DW-1:0] e;
        rb = model_bank ? 0 : 1;
        for (int c = lo; c <= hi; c++) begin
            @(negedge clk);
            hdump   = AW'(c);
            LHBL    = lhbl;
            pxl_cen = 1'b1;
            e = lhbl ? model[rb][c] : '0;
            if (lhbl) model[rb][c] = '0;
            if (chk) exp_q.push_back(e);
            @(negedge clk);
            pxl_cen = 1'b0;
            if (chk) check("pxl", pxl, exp_q.pop_front());
        end
        @(negedge clk);
        LHBL = 1'b1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus.buf_we   = 1'b0;
        bus.buf_addr = '0;
        bus.buf_data = '0;
        model_bank   = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 256; c++) model[b][c] = '0;

        repeat (2) @(negedge clk);
        check("rst_pxl", pxl, 0);
        check("rst_bank", wr_bank, 0);
        check("rst_ok", bus.buf_ok, PRIO ? 0 : 1);
        rst = 1'b0;
        @(negedge clk);
        check("ok_after_rst", bus.buf_ok, 1);

        // Blank both banks so RAM power-up contents do not matter.
        scan(0, 255, 1'b1, 1'b0);
        hs_pulse();
        scan(0, 255, 1'b1, 1'b0);
        hs_pulse();

        write_px(8'd10, 8'h15);
        write_px(8'd3, 8'h17);
        write_px(8'd3, 8'h20);
        write_px(8'd40, 8'h11);
        write_px(8'd40, 8'h22);
        write_px(8'd200, 8'h2c);
        hs_pulse();
        scan(0, 255, 1'b1, 1'b1);
        hs_pulse();
        scan(0, 255, 1'b1, 1'b1);
        hs_pulse();
        scan(0, 255, 1'b1, 1'b1);

        write_px(8'd255, 8'h3e);
        hs_with_write(8'd5, 8'h33);
        scan(0, 15, 1'b1, 1'b1);
        scan(250, 255, 1'b1, 1'b1);
        hs_pulse();
        scan(0, 15, 1'b1, 1'b1);
        scan(250, 255, 1'b1, 1'b1);

        write_px(8'd20, 8'h44);
        write_px(8'd21, 8'h45);
        write_px(8'd23, 8'h4f);
        hs_pulse();
        scan(16, 24, 1'b0, 1'b1);
        scan(16, 24, 1'b1, 1'b1);

        write_px(8'd8, 8'h55);
        write_px(8'd12, 8'h56);
        hs_pulse();
        scan(8, 8, 1'b1, 1'b1);
`ifdef JTCOP_OBJ_PRIO_EN
        @(negedge clk);
        bus.buf_we   = 1'b1;
        bus.buf_addr = 8'd9;
        bus.buf_data = 8'h77;
        @(negedge clk);
        bus.buf_we = 1'b0;
        check("in_chk", wr_st, 2);
        rst = 1'b1;
`else
        @(negedge clk);
        rst = 1'b1;
`endif
        #1;
        check("mid_rst_pxl", pxl, 0);
        check("mid_rst_bank", wr_bank, 0);
        model_bank = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ok_after_mid_rst", bus.buf_ok, 1);
        scan(0, 15, 1'b1, 1'b1);
        hs_pulse();
        scan(0, 15, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
